// File: rtl/daxi_arb_pkg.sv
// Shared types and defaults for the DAXI arbiter: requester IDs and
// the default depth of the outstanding-read ID tracker.
package daxi_arb_pkg;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_LSU = 1'b0;
    localparam req_id_t REQ_DBG = 1'b1;

    localparam int RD_DEPTH_DEF = 4;

endpackage

// File: rtl/daxi_arb_id_fifo.sv
// In-order tracker of requester IDs for outstanding DAXI reads.
// Full/empty come from the count before this cycle's push/pop.
module daxi_arb_id_fifo
    import daxi_arb_pkg::*;
#(
    parameter int DEPTH = RD_DEPTH_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  req_id_t din,
    output req_id_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_id_t        mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           push_ok_s, pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == {CW{1'b0}});
    assign dout      = mem_q[rd_ptr_q];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Next-state for pointers and occupancy; pointers wrap on the power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= REQ_LSU;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= din;
            end
        end
    end

endmodule

// File: rtl/daxi_arbiter.sv
// Two-requester arbiter for the data-AXI port with in-order read-return routing.
// Define DAXI_ARB_RR_EN for round-robin; otherwise m0 has fixed priority.
module daxi_arbiter
    import daxi_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_DEPTH   = RD_DEPTH_DEF
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_resetn,
    input  logic                  m0_access,
    input  logic                  m0_rd0_wr1,
    input  logic [3:0]            m0_byte_strobe,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic                  m0_accept,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    output logic                  m0_read_data_valid,
    input  logic                  m1_access,
    input  logic                  m1_rd0_wr1,
    input  logic [3:0]            m1_byte_strobe,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic                  m1_accept,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  m1_read_data_valid,
    output logic                  DAXI_access,
    output logic [3:0]            DAXI_byte_strobe,
    output logic                  DAXI_rd0_wr1,
    output logic [ADDR_WIDTH-1:0] DAXI_addr,
    output logic [DATA_WIDTH-1:0] DAXI_write_data,
    input  logic                  DAXI_trans_buffer_full,
    input  logic [DATA_WIDTH-1:0] DAXI_read_data,
    input  logic                  DAXI_read_data_valid,
    output logic                  arb_err
);

    logic    slot_open_s, rd_room_s;
    logic    elig0_s, elig1_s, gnt0_s, gnt1_s;
    logic    push_s, pop_s, fifo_full_s, fifo_empty_s;
    req_id_t push_id_s, fifo_dout_s;
    logic    arb_err_q, arb_err_d;

    // A write only needs DAXI room, so a full ID tracker never blocks writes.
    assign slot_open_s = !DAXI_trans_buffer_full;
    assign rd_room_s   = slot_open_s && !fifo_full_s;
    assign elig0_s     = m0_access && (m0_rd0_wr1 ? slot_open_s : rd_room_s);
    assign elig1_s     = m1_access && (m1_rd0_wr1 ? slot_open_s : rd_room_s);

`ifdef DAXI_ARB_RR_EN
    req_id_t rr_last_q, rr_last_d;

    // Remember the most recent grantee for the next contention.
    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt0_s) begin
            rr_last_d = REQ_LSU;
        end else if (gnt1_s) begin
            rr_last_d = REQ_DBG;
        end else begin
            rr_last_d = rr_last_q;
        end
    end

    // Round-robin history; reset to DBG so LSU wins the first contention.
    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            rr_last_q <= REQ_DBG;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // Single grant per cycle among eligible requesters.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (elig0_s && elig1_s) begin
`ifdef DAXI_ARB_RR_EN
            gnt0_s = (rr_last_q != REQ_LSU);
            gnt1_s = (rr_last_q == REQ_LSU);
`else
            gnt0_s = 1'b1;
            gnt1_s = 1'b0;
`endif
        end else begin
            gnt0_s = elig0_s;
            gnt1_s = elig1_s;
        end
    end

    // Drive the granted request onto DAXI; zeros when nothing is granted.
    always_comb begin
        DAXI_access      = gnt0_s || gnt1_s;
        DAXI_byte_strobe = 4'b0000;
        DAXI_rd0_wr1     = 1'b0;
        DAXI_addr        = {ADDR_WIDTH{1'b0}};
        DAXI_write_data  = {DATA_WIDTH{1'b0}};
        if (gnt0_s) begin
            DAXI_byte_strobe = m0_byte_strobe;
            DAXI_rd0_wr1     = m0_rd0_wr1;
            DAXI_addr        = m0_addr;
            DAXI_write_data  = m0_write_data;
        end else if (gnt1_s) begin
            DAXI_byte_strobe = m1_byte_strobe;
            DAXI_rd0_wr1     = m1_rd0_wr1;
            DAXI_addr        = m1_addr;
            DAXI_write_data  = m1_write_data;
        end else begin
            DAXI_access      = 1'b0;
        end
    end

    assign m0_accept = gnt0_s;
    assign m1_accept = gnt1_s;
    assign push_s    = (gnt0_s && !m0_rd0_wr1) || (gnt1_s && !m1_rd0_wr1);
    assign push_id_s = gnt1_s ? REQ_DBG : REQ_LSU;
    assign pop_s     = DAXI_read_data_valid && !fifo_empty_s;

    daxi_arb_id_fifo #(
        .DEPTH (RD_DEPTH)
    ) u_id_fifo (
        .clk   (cpu_clk),
        .rst_n (cpu_resetn),
        .push  (push_s),
        .pop   (pop_s),
        .din   (push_id_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Steer returned read data to the requester at the head of the tracker.
    always_comb begin
        m0_read_data       = {DATA_WIDTH{1'b0}};
        m1_read_data       = {DATA_WIDTH{1'b0}};
        m0_read_data_valid = 1'b0;
        m1_read_data_valid = 1'b0;
        if (pop_s && (fifo_dout_s == REQ_LSU)) begin
            m0_read_data       = DAXI_read_data;
            m0_read_data_valid = 1'b1;
        end else if (pop_s) begin
            m1_read_data       = DAXI_read_data;
            m1_read_data_valid = 1'b1;
        end else begin
            m0_read_data_valid = 1'b0;
        end
    end

    assign arb_err_d = arb_err_q | (DAXI_read_data_valid & fifo_empty_s);
    assign arb_err   = arb_err_q;

    // Sticky flag for a read return that has no outstanding owner.
    always_ff @(posedge cpu_clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            arb_err_q <= 1'b0;
        end else begin
            arb_err_q <= arb_err_d;
        end
    end

endmodule

// File: tb/tb_daxi_arbiter.sv
// Self-checking bench for daxi_arbiter: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_daxi_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int D  = 4;

    logic          cpu_clk = 1'b0;
    logic          cpu_resetn;
    logic          m0_access, m0_rd0_wr1, m1_access, m1_rd0_wr1;
    logic [3:0]    m0_byte_strobe, m1_byte_strobe;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_write_data, m1_write_data;
    logic          m0_accept, m1_accept, m0_read_data_valid, m1_read_data_valid;
    logic [DW-1:0] m0_read_data, m1_read_data;
    logic          DAXI_access, DAXI_rd0_wr1, DAXI_trans_buffer_full, DAXI_read_data_valid;
    logic [3:0]    DAXI_byte_strobe;
    logic [AW-1:0] DAXI_addr;
    logic [DW-1:0] DAXI_write_data, DAXI_read_data;
    logic          arb_err;

    daxi_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_DEPTH(D)) dut (
        .cpu_clk(cpu_clk), .cpu_resetn(cpu_resetn),
        .m0_access(m0_access), .m0_rd0_wr1(m0_rd0_wr1), .m0_byte_strobe(m0_byte_strobe),
        .m0_addr(m0_addr), .m0_write_data(m0_write_data), .m0_accept(m0_accept),
        .m0_read_data(m0_read_data), .m0_read_data_valid(m0_read_data_valid),
        .m1_access(m1_access), .m1_rd0_wr1(m1_rd0_wr1), .m1_byte_strobe(m1_byte_strobe),
        .m1_addr(m1_addr), .m1_write_data(m1_write_data), .m1_accept(m1_accept),
        .m1_read_data(m1_read_data), .m1_read_data_valid(m1_read_data_valid),
        .DAXI_access(DAXI_access), .DAXI_byte_strobe(DAXI_byte_strobe),
        .DAXI_rd0_wr1(DAXI_rd0_wr1), .DAXI_addr(DAXI_addr), .DAXI_write_data(DAXI_write_data),
        .DAXI_trans_buffer_full(DAXI_trans_buffer_full), .DAXI_read_data(DAXI_read_data),
        .DAXI_read_data_valid(DAXI_read_data_valid), .arb_err(arb_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: owners of outstanding reads, last grantee, sticky error.
    int id_q[$];
    int rr_last;
    bit err_m;
    int last_grant;

    // DUT outputs sampled in the most recent step.
    logic          s_acc0, s_acc1, s_access, s_v0, s_v1, s_err, s_wr;
    logic [DW-1:0] s_d0, s_d1;
    logic [AW-1:0] s_addr;
    logic [3:0]    s_strb;

    typedef struct {
        logic [5:0]  in;    // {a0, w0, a1, w1, full, rv}
        logic [31:0] rdata;
        logic [5:0]  exp;   // {acc0, acc1, access, v0, v1, err}
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        m0_access = 1'b0; m0_rd0_wr1 = 1'b0; m0_byte_strobe = 4'h0; m0_addr = '0; m0_write_data = '0;
        m1_access = 1'b0; m1_rd0_wr1 = 1'b0; m1_byte_strobe = 4'h0; m1_addr = '0; m1_write_data = '0;
        DAXI_trans_buffer_full = 1'b0; DAXI_read_data_valid = 1'b0; DAXI_read_data = '0;
    endtask

    // One cycle: compare every output against the model at the falling edge, then advance.
    task automatic step();
        bit slot, rdok, e0, e1, ev0, ev1, er;
        int g;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew, ed0, ed1;
        logic [3:0] es;
        @(negedge cpu_clk);
        s_acc0 = m0_accept; s_acc1 = m1_accept; s_access = DAXI_access;
        s_v0 = m0_read_data_valid; s_v1 = m1_read_data_valid; s_err = arb_err;
        s_d0 = m0_read_data; s_d1 = m1_read_data; s_addr = DAXI_addr;
        s_strb = DAXI_byte_strobe; s_wr = DAXI_rd0_wr1;
        slot = !DAXI_trans_buffer_full;
        rdok = slot && (id_q.size() < D);
        e0 = m0_access && (m0_rd0_wr1 ? slot : rdok);
        e1 = m1_access && (m1_rd0_wr1 ? slot : rdok);
        g = -1;
        if (e0 && e1) begin
`ifdef DAXI_ARB_RR_EN
            g = (rr_last == 0) ? 1 : 0;
`else
            g = 0;
`endif
        end else if (e0) g = 0;
        else if (e1) g = 1;
        ea = '0; ew = '0; es = 4'h0; er = 1'b0;
        if (g == 0) begin ea = m0_addr; ew = m0_write_data; es = m0_byte_strobe; er = m0_rd0_wr1; end
        if (g == 1) begin ea = m1_addr; ew = m1_write_data; es = m1_byte_strobe; er = m1_rd0_wr1; end
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        if (DAXI_read_data_valid && id_q.size() > 0) begin
            if (id_q[0] == 0) begin ev0 = 1'b1; ed0 = DAXI_read_data; end
            else begin ev1 = 1'b1; ed1 = DAXI_read_data; end
        end
        chk("m0_accept", s_acc0, g == 0);
        chk("m1_accept", s_acc1, g == 1);
        chk("DAXI_access", s_access, g >= 0);
        chk("DAXI_addr", s_addr, ea);
        chk("DAXI_write_data", DAXI_write_data, ew);
        chk("DAXI_byte_strobe", s_strb, es);
        chk("DAXI_rd0_wr1", s_wr, er);
        chk("m0_rvalid", s_v0, ev0);
        chk("m1_rvalid", s_v1, ev1);
        chk("m0_rdata", s_d0, ed0);
        chk("m1_rdata", s_d1, ed1);
        chk("arb_err", s_err, err_m);
        if (cpu_resetn) begin
            if (DAXI_read_data_valid) begin
                if (id_q.size() > 0) void'(id_q.pop_front());
                else err_m = 1'b1;
            end
            if (g >= 0) begin
                if (!er) id_q.push_back(g);
                rr_last = g;
            end
        end
        last_grant = g;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        cpu_resetn = 1'b0;
        id_q.delete(); rr_last = 1; err_m = 1'b0;
        step();
        step();
        cpu_resetn = 1'b1;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 2 * D && id_q.size() > 0; k++) begin
            DAXI_read_data_valid = 1'b1;
            DAXI_read_data = $urandom;
            step();
        end
        chk("drain_empty", id_q.size(), 0);
        idle();
    endtask

    initial begin
        int n1;
        cpu_resetn = 1'b0;
        idle();
        id_q.delete(); rr_last = 1; err_m = 1'b0; last_grant = -1;
        step();
        chk("reset_access", s_access, 1'b0);
        chk("reset_err", s_err, 1'b0);
        cpu_resetn = 1'b1;

        // Vector table from a clean reset.
        tbl[0] = '{6'b100000, 32'h0000_0000, 6'b101000};
        tbl[1] = '{6'b001000, 32'h0000_0000, 6'b011000};
        tbl[2] = '{6'b111110, 32'h0000_0000, 6'b000000};
        tbl[3] = '{6'b101001, 32'h1111_1111, 6'b101100};
        tbl[4] = '{6'b001101, 32'h2222_2222, 6'b011010};
        tbl[5] = '{6'b000001, 32'h3333_3333, 6'b000100};
        tbl[6] = '{6'b000001, 32'h4444_4444, 6'b000000};
        tbl[7] = '{6'b110000, 32'h0000_0000, 6'b101001};
        tbl[8] = '{6'b001100, 32'h0000_0000, 6'b011001};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            idle();
            {m0_access, m0_rd0_wr1, m1_access, m1_rd0_wr1, DAXI_trans_buffer_full, DAXI_read_data_valid} = tbl[i].in;
            DAXI_read_data = tbl[i].rdata;
            m0_addr = 32'h1000 + 32'(i * 4); m1_addr = 32'h2000 + 32'(i * 4);
            m0_write_data = 32'hA000_0000 + 32'(i); m1_write_data = 32'hB000_0000 + 32'(i);
            m0_byte_strobe = 4'hF; m1_byte_strobe = 4'h5;
            step();
            chk("tbl_out", {s_acc0, s_acc1, s_access, s_v0, s_v1, s_err}, tbl[i].exp);
        end

        // Single m0 read with a return three cycles later.
        do_reset();
        m0_access = 1'b1; m0_addr = 32'h100;
        step();
        chk("t1_accept", s_acc0, 1'b1);
        chk("t1_addr", s_addr, 32'h100);
        idle(); step(); step();
        DAXI_read_data_valid = 1'b1; DAXI_read_data = 32'hDEAD_BEEF;
        step();
        chk("t1_valid", s_v0, 1'b1);
        chk("t1_data", s_d0, 32'hDEAD_BEEF);
        chk("t1_m1_valid", s_v1, 1'b0);
        idle();

        // Both requesters read every cycle; returns keep the tracker from filling.
        do_reset();
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            m0_access = 1'b1; m1_access = 1'b1;
            m0_addr = 32'h3000 + 32'(i); m1_addr = 32'h4000 + 32'(i);
            DAXI_read_data_valid = (i > 0); DAXI_read_data = 32'(i);
            step();
            if (last_grant == 1) n1++;
`ifdef DAXI_ARB_RR_EN
            chk("t2_grant", last_grant, i % 2);
`else
            chk("t2_grant", last_grant, 0);
`endif
        end
`ifdef DAXI_ARB_RR_EN
        chk("t2_m1_grants", n1, 4);
`else
        chk("t2_m1_grants", n1, 0);
`endif
        drain();

        // Full tracker: write still issues; read waits one cycle past the pop.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); m1_access = 1'b1; m1_addr = 32'h500 + 32'(i * 4);
            step();
            chk("t3_fill", s_acc1, 1'b1);
        end
        m0_access = 1'b1; m0_rd0_wr1 = 1'b1; m0_addr = 32'h200;
        m0_byte_strobe = 4'b0011; m0_write_data = 32'hCAFE_0000;
        step();
        chk("t3_wr_accept", s_acc0, 1'b1);
        chk("t3_rd_blocked", s_acc1, 1'b0);
        chk("t3_wr_addr", s_addr, 32'h200);
        chk("t3_wr_strobe", s_strb, 4'b0011);
        m0_access = 1'b0;
        DAXI_read_data_valid = 1'b1; DAXI_read_data = 32'h5555_0001;
        step();
        chk("t3_pop_cycle", s_acc1, 1'b0);
        chk("t3_pop_valid", s_v1, 1'b1);
        DAXI_read_data_valid = 1'b0;
        step();
        chk("t3_after_pop", s_acc1, 1'b1);
        drain();

        // Interleaved owners returned in order.
        do_reset();
        idle(); m0_access = 1'b1; step();
        idle(); m1_access = 1'b1; step();
        idle(); m0_access = 1'b1; step();
        idle(); DAXI_read_data_valid = 1'b1;
        DAXI_read_data = 32'hAAAA_AAAA; step();
        chk("t4_a", {s_v0, s_v1, s_d0}, {2'b10, 32'hAAAA_AAAA});
        DAXI_read_data = 32'hBBBB_BBBB; step();
        chk("t4_b", {s_v0, s_v1, s_d1}, {2'b01, 32'hBBBB_BBBB});
        DAXI_read_data = 32'hCCCC_CCCC; step();
        chk("t4_c", {s_v0, s_v1, s_d0}, {2'b10, 32'hCCCC_CCCC});
        idle();

        // DAXI full holds everything off; first issue when it drops.
        do_reset();
        m0_access = 1'b1; m1_access = 1'b1; DAXI_trans_buffer_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_blocked", s_access, 1'b0);
        end
        DAXI_trans_buffer_full = 1'b0;
        step();
        chk("t5_issue", {s_access, s_acc0}, 2'b11);
        drain();

        // Orphan return sets the sticky error; reset mid-burst clears state.
        do_reset();
        DAXI_read_data_valid = 1'b1; DAXI_read_data = 32'h1234_5678;
        step();
        chk("t6_no_valid", {s_v0, s_v1}, 2'b00);
        idle(); step();
        chk("t6_err", s_err, 1'b1);
        m0_access = 1'b1; step(); step();
        idle();
        cpu_resetn = 1'b0;
        id_q.delete(); rr_last = 1; err_m = 1'b0;
        step();
        chk("t6_rst_err", s_err, 1'b0);
        chk("t6_rst_access", s_access, 1'b0);
        cpu_resetn = 1'b1;
        DAXI_read_data_valid = 1'b1; DAXI_read_data = 32'h0BAD_0BAD;
        step();
        chk("t6_post_valid", {s_v0, s_v1}, 2'b00);
        idle(); step();
        chk("t6_post_err", s_err, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            m0_access = 1'($urandom_range(0, 1)); m0_rd0_wr1 = 1'($urandom_range(0, 1));
            m1_access = 1'($urandom_range(0, 1)); m1_rd0_wr1 = 1'($urandom_range(0, 1));
            m0_byte_strobe = 4'($urandom); m1_byte_strobe = 4'($urandom);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_write_data = $urandom; m1_write_data = $urandom;
            DAXI_trans_buffer_full = ($urandom_range(0, 3) == 0);
            DAXI_read_data_valid = (id_q.size() > 0) && ($urandom_range(0, 1) == 1);
            DAXI_read_data = $urandom;
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
